kamus_lsu_ctrl: RTL and testbench

Load/store sequencer between the kamus-v execute stage and the L1 data cache port. Accepts one memory operation at a time, checks alignment, and drives a req/gnt + rvalid handshake toward L1D with word address, byte enables and lane-shifted write data. Returns sign- or zero-extended load data and stalls the pipeline while an access is outstanding. It replaces the single-cycle `l1d_wr_en` path from the control unit for all load and store operations.

---
 rtl/kamus_pkg.sv | 76 +++++++
 rtl/kamus_lsu_align.sv | 53 +++++
 rtl/kamus_lsu_ctrl.sv | 179 +++++++++++++++++
 tb/tb_kamus_lsu_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kamus_pkg.sv
// kamus_pkg: shared types for the kamus-v core, including the load/store unit
// operation decode, access sizes and sequencer states.
package kamus_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_SLL = 4'h6,
        OP_SRL = 4'h7,
        OP_LB  = 4'h8,
        OP_LH  = 4'h9,
        OP_LW  = 4'hA,
        OP_LBU = 4'hB,
        OP_LHU = 4'hC,
        OP_SB  = 4'hD,
        OP_SH  = 4'hE,
        OP_SW  = 4'hF
    } operation_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        LSU_IDLE     = 3'd0,
        LSU_REQ      = 3'd1,
        LSU_WAIT_RSP = 3'd2,
        LSU_DONE     = 3'd3,
        LSU_DRAIN    = 3'd4
    } lsu_state_t;

    typedef struct packed {
        logic      is_mem;
        mem_size_t size;
        logic      sign;
        logic      store;
    } mem_op_info_t;

    // Non-memory operations come back with is_mem = 0 so the LSU ignores them.
    function automatic mem_op_info_t decode_mem_op(input operation_t op);
        mem_op_info_t info;
        info = '{is_mem: 1'b0, size: MEM_WORD, sign: 1'b0, store: 1'b0};
        case (op)
            OP_LB:   info = '{is_mem: 1'b1, size: MEM_BYTE, sign: 1'b1, store: 1'b0};
            OP_LH:   info = '{is_mem: 1'b1, size: MEM_HALF, sign: 1'b1, store: 1'b0};
            OP_LW:   info = '{is_mem: 1'b1, size: MEM_WORD, sign: 1'b0, store: 1'b0};
            OP_LBU:  info = '{is_mem: 1'b1, size: MEM_BYTE, sign: 1'b0, store: 1'b0};
            OP_LHU:  info = '{is_mem: 1'b1, size: MEM_HALF, sign: 1'b0, store: 1'b0};
            OP_SB:   info = '{is_mem: 1'b1, size: MEM_BYTE, sign: 1'b0, store: 1'b1};
            OP_SH:   info = '{is_mem: 1'b1, size: MEM_HALF, sign: 1'b0, store: 1'b1};
            OP_SW:   info = '{is_mem: 1'b1, size: MEM_WORD, sign: 1'b0, store: 1'b1};
            default: info = '{is_mem: 1'b0, size: MEM_WORD, sign: 1'b0, store: 1'b0};
        endcase
        return info;
    endfunction

    function automatic logic is_aligned(input mem_size_t size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            MEM_BYTE: ok = 1'b1;
            MEM_HALF: ok = ~addr_lo[0];
            MEM_WORD: ok = (addr_lo == 2'b00);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// kamus_lsu_align: lane logic for the LSU. The write side turns a request into
// byte enables plus lane-replicated store data; the read side picks the
// addressed lane out of the returned word and extends it to 32 bits.
module kamus_lsu_align
    import kamus_pkg::*;
(
    input  mem_size_t   i_wr_size,
    input  logic [1:0]  i_wr_addr_lo,
    input  logic [31:0] i_wr_data,
    output logic [3:0]  o_wr_be,
    output logic [31:0] o_wr_data,
    input  mem_size_t   i_rd_size,
    input  logic        i_rd_sign,
    input  logic [1:0]  i_rd_addr_lo,
    input  logic [31:0] i_rd_word,
    output logic [31:0] o_rd_data
);

    logic [31:0] w_rd_shifted;

    // Store lanes: the value is replicated so every lane carries it and the
    // byte enables alone decide which bytes the cache writes.
    always_comb begin
        o_wr_be   = 4'b1111;
        o_wr_data = i_wr_data;
        case (i_wr_size)
            MEM_BYTE: begin
                o_wr_be   = 4'b0001 << i_wr_addr_lo;
                o_wr_data = {4{i_wr_data[7:0]}};
            end
            MEM_HALF: begin
                o_wr_be   = 4'b0011 << i_wr_addr_lo;
                o_wr_data = {2{i_wr_data[15:0]}};
            end
            default: begin
                o_wr_be   = 4'b1111;
                o_wr_data = i_wr_data;
            end
        endcase
    end

    // Load lanes: shift the addressed byte/half down to bit 0, then extend.
    always_comb begin
        w_rd_shifted = i_rd_word >> {i_rd_addr_lo, 3'b000};
        o_rd_data    = i_rd_word;
        case (i_rd_size)
            MEM_BYTE: o_rd_data = {{24{i_rd_sign & w_rd_shifted[7]}}, w_rd_shifted[7:0]};
            MEM_HALF: o_rd_data = {{16{i_rd_sign & w_rd_shifted[15]}}, w_rd_shifted[15:0]};
            default:  o_rd_data = i_rd_word;
        endcase
    end

endmodule

// File: rtl/kamus_lsu_ctrl.sv
// kamus_lsu_ctrl: load/store sequencer between execute and the L1D port.
// One operation in flight at a time; request fields are registered at accept
// and held unchanged until the cache grants.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no access; may accept a new op
// REQ      | l1d_req_o high, waiting for l1d_gnt_i
// WAIT_RSP | load granted, waiting for l1d_rvalid_i
// DONE     | done_o pulse; may accept the next op back-to-back
// DRAIN    | flushed load, swallow its rvalid before going idle
module kamus_lsu_ctrl
    import kamus_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    input  operation_t      req_op_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o,
    output logic            l1d_req_o,
    output logic            l1d_we_o,
    output logic [XLEN-1:0] l1d_addr_o,
    output logic [3:0]      l1d_be_o,
    output logic [XLEN-1:0] l1d_wdata_o,
    input  logic            l1d_gnt_i,
    input  logic            l1d_rvalid_i,
    input  logic [XLEN-1:0] l1d_rdata_i
);

    lsu_state_t      r_state;
    lsu_state_t      w_state_nxt;
    mem_op_info_t    w_req_info;
    logic            w_req_aligned;
    logic            w_can_accept;
    logic            w_new_op;
    logic            w_accept;
    logic            w_misalign;
    logic            w_load_cplt;
    logic            w_stall;
    logic            w_done;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_lane;
    logic [XLEN-1:0] w_rdata_ext;

    mem_size_t       r_size;
    logic            r_sign;
    logic            r_we;
    logic [1:0]      r_addr_lo;
    logic [XLEN-1:0] r_addr;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_misaligned;

    assign w_req_info    = decode_mem_op(req_op_i);
    assign w_req_aligned = is_aligned(w_req_info.size, req_addr_i[1:0]);
    assign w_can_accept  = (r_state == LSU_IDLE) || (r_state == LSU_DONE);
    // Flush wins over a new request: nothing is accepted or rejected that cycle.
    assign w_new_op      = w_can_accept && req_valid_i && w_req_info.is_mem && !flush_i;
    assign w_accept      = w_new_op && w_req_aligned;
    assign w_misalign    = w_new_op && !w_req_aligned;
    assign w_load_cplt   = (r_state == LSU_WAIT_RSP) && l1d_rvalid_i && !flush_i;

    kamus_lsu_align u_align (
        .i_wr_size    (w_req_info.size),
        .i_wr_addr_lo (req_addr_i[1:0]),
        .i_wr_data    (req_wdata_i),
        .o_wr_be      (w_be),
        .o_wr_data    (w_wdata_lane),
        .i_rd_size    (r_size),
        .i_rd_sign    (r_sign),
        .i_rd_addr_lo (r_addr_lo),
        .i_rd_word    (l1d_rdata_i),
        .o_rd_data    (w_rdata_ext)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus stall/done.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                w_stall     = w_accept;
                w_state_nxt = w_accept ? LSU_REQ : LSU_IDLE;
            end
            LSU_DONE: begin
                w_done      = 1'b1;
                w_stall     = w_accept;
                w_state_nxt = w_accept ? LSU_REQ : LSU_IDLE;
            end
            LSU_REQ: begin
                w_stall = 1'b1;
                if (flush_i) begin
                    // A granted load still owes us an rvalid; a granted store
                    // simply completes without reporting.
                    w_state_nxt = (l1d_gnt_i && !r_we) ? LSU_DRAIN : LSU_IDLE;
                end else if (l1d_gnt_i) begin
                    w_state_nxt = r_we ? LSU_DONE : LSU_WAIT_RSP;
                end
            end
            LSU_WAIT_RSP: begin
                w_stall = 1'b1;
                if (l1d_rvalid_i) begin
                    // Flush coinciding with rvalid has nothing left to drain.
                    w_state_nxt = flush_i ? LSU_IDLE : LSU_DONE;
                end else if (flush_i) begin
                    w_state_nxt = LSU_DRAIN;
                end
            end
            LSU_DRAIN: begin
                w_stall = 1'b1;
                if (l1d_rvalid_i) begin
                    w_state_nxt = LSU_IDLE;
                end
            end
            default: begin
                w_state_nxt = LSU_IDLE;
            end
        endcase
    end

    // Request latch at accept, load result capture, misaligned pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_size       <= MEM_BYTE;
            r_sign       <= 1'b0;
            r_we         <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_addr       <= '0;
            r_be         <= 4'b0000;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_misalign;
            if (w_accept) begin
                r_size    <= w_req_info.size;
                r_sign    <= w_req_info.sign;
                r_we      <= w_req_info.store;
                r_addr_lo <= req_addr_i[1:0];
                r_addr    <= {req_addr_i[XLEN-1:2], 2'b00};
                r_be      <= w_be;
                r_wdata   <= w_wdata_lane;
            end
            if (w_load_cplt) begin
                r_rdata <= w_rdata_ext;
            end
        end
    end

    assign stall_o      = w_stall;
    assign done_o       = w_done;
    assign rdata_o      = r_rdata;
    assign misaligned_o = r_misaligned;
    assign l1d_req_o    = (r_state == LSU_REQ);
    assign l1d_we_o     = r_we;
    assign l1d_addr_o   = r_addr;
    assign l1d_be_o     = r_be;
    assign l1d_wdata_o  = r_wdata;

endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// tb_kamus_lsu_ctrl: directed vectors with hand-computed results, plus
// sequences for flush, back-to-back and reset corner cases.
module tb_kamus_lsu_ctrl;
    import kamus_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i;
    operation_t  req_op_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misaligned_o;
    logic        l1d_req_o;
    logic        l1d_we_o;
    logic [31:0] l1d_addr_o;
    logic [3:0]  l1d_be_o;
    logic [31:0] l1d_wdata_o;
    logic        l1d_gnt_i;
    logic        l1d_rvalid_i;
    logic [31:0] l1d_rdata_i;

    int          total = 0;
    int          bad = 0;
    logic [31:0] hold_rdata = 32'h0;

    typedef struct {
        operation_t  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          gd;
        int          rd;
        logic        mis;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[15];

    kamus_lsu_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_op_i     (req_op_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .misaligned_o (misaligned_o),
        .l1d_req_o    (l1d_req_o),
        .l1d_we_o     (l1d_we_o),
        .l1d_addr_o   (l1d_addr_o),
        .l1d_be_o     (l1d_be_o),
        .l1d_wdata_o  (l1d_wdata_o),
        .l1d_gnt_i    (l1d_gnt_i),
        .l1d_rvalid_i (l1d_rvalid_i),
        .l1d_rdata_i  (l1d_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic quiet_inputs();
        req_valid_i  = 1'b0;
        req_op_i     = OP_NOP;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        flush_i      = 1'b0;
        l1d_gnt_i    = 1'b0;
        l1d_rvalid_i = 1'b0;
        l1d_rdata_i  = 32'hDEAD_0000;
    endtask

    task automatic chk_req(input string tag, input vec_t v);
        chk({tag, "_req"},   {31'b0, l1d_req_o}, 32'd1);
        chk({tag, "_we"},    {31'b0, l1d_we_o},  {31'b0, v.e_we});
        chk({tag, "_addr"},  l1d_addr_o,         v.e_addr);
        chk({tag, "_be"},    {28'b0, l1d_be_o},  {28'b0, v.e_be});
        chk({tag, "_wdata"}, l1d_wdata_o,        v.e_wdata);
        chk({tag, "_stall"}, {31'b0, stall_o},   32'd1);
    endtask

    // Present one op at c0 and play the L1D side with the vector's delays.
    task automatic run_vec(input string tag, input vec_t v);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i    = v.op;
        req_addr_i  = v.addr;
        req_wdata_i = v.wdata;
        #1;
        chk({tag, "_stall_c0"}, {31'b0, stall_o}, {31'b0, !v.mis});
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_op_i    = OP_NOP;
        #1;
        chk({tag, "_mis_c1"}, {31'b0, misaligned_o}, {31'b0, v.mis});
        if (v.mis) begin
            chk({tag, "_noreq_c1"}, {31'b0, l1d_req_o}, 32'd0);
            chk({tag, "_nostall_c1"}, {31'b0, stall_o}, 32'd0);
            @(negedge clk_i);
            #1;
            chk({tag, "_mis_c2"}, {31'b0, misaligned_o}, 32'd0);
            chk({tag, "_noreq_c2"}, {31'b0, l1d_req_o}, 32'd0);
            chk({tag, "_rdata_keep"}, rdata_o, hold_rdata);
            return;
        end
        for (int k = 0; k < v.gd; k++) begin
            chk_req({tag, "_gw"}, v);
            chk({tag, "_gw_done"}, {31'b0, done_o}, 32'd0);
            @(negedge clk_i);
            #1;
        end
        chk_req({tag, "_g"}, v);
        l1d_gnt_i = 1'b1;
        @(negedge clk_i);
        l1d_gnt_i = 1'b0;
        #1;
        if (!v.e_we) begin
            for (int k = 0; k < v.rd; k++) begin
                chk({tag, "_rw_stall"}, {31'b0, stall_o}, 32'd1);
                chk({tag, "_rw_req"}, {31'b0, l1d_req_o}, 32'd0);
                @(negedge clk_i);
                #1;
            end
            chk({tag, "_rsp_stall"}, {31'b0, stall_o}, 32'd1);
            l1d_rvalid_i = 1'b1;
            l1d_rdata_i  = v.word;
            @(negedge clk_i);
            l1d_rvalid_i = 1'b0;
            l1d_rdata_i  = 32'hDEAD_0000;
            #1;
            hold_rdata = v.e_rdata;
        end
        chk({tag, "_done"}, {31'b0, done_o}, 32'd1);
        chk({tag, "_done_stall"}, {31'b0, stall_o}, 32'd0);
        chk({tag, "_rdata"}, rdata_o, hold_rdata);
        chk({tag, "_done_req"}, {31'b0, l1d_req_o}, 32'd0);
        @(negedge clk_i);
        #1;
        chk({tag, "_done_pulse"}, {31'b0, done_o}, 32'd0);
    endtask

    initial begin
        //          op      addr          wdata         word          gd rd mis  we    e_addr        e_be     e_wdata       e_rdata
        vecs[0]  = '{OP_SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 1'b0, 1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{OP_LB,  32'h0000_0103, 32'h0,         32'h80FF_1234, 2, 0, 1'b0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,         32'hFFFF_FF80};
        vecs[2]  = '{OP_LBU, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0, 0, 1'b0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,         32'h0000_0080};
        vecs[3]  = '{OP_SH,  32'h0000_0202, 32'h0000_ABCD, 32'h0,        0, 0, 1'b0, 1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[4]  = '{OP_LH,  32'h0000_0201, 32'h0,         32'h0,        0, 0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[5]  = '{OP_LW,  32'h0000_01FC, 32'h0,         32'h1234_5678, 1, 2, 1'b0, 1'b0, 32'h0000_01FC, 4'b1111, 32'h0,         32'h1234_5678};
        vecs[6]  = '{OP_LH,  32'h0000_0102, 32'h0,         32'h80FF_1234, 0, 1, 1'b0, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,         32'hFFFF_80FF};
        vecs[7]  = '{OP_LHU, 32'h0000_0100, 32'h0,         32'h80FF_1234, 1, 0, 1'b0, 1'b0, 32'h0000_0100, 4'b0011, 32'h0,         32'h0000_1234};
        vecs[8]  = '{OP_LB,  32'h0000_0101, 32'h0,         32'h80FF_1234, 0, 0, 1'b0, 1'b0, 32'h0000_0100, 4'b0010, 32'h0,         32'h0000_0012};
        vecs[9]  = '{OP_SB,  32'h0000_0001, 32'h0000_00A5, 32'h0,        3, 0, 1'b0, 1'b1, 32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[10] = '{OP_SW,  32'h0000_0006, 32'h1111_2222, 32'h0,        0, 0, 1'b1, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[11] = '{OP_LW,  32'h0000_0002, 32'h0,         32'h0,        0, 0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[12] = '{OP_LBU, 32'h0000_0102, 32'h0,         32'h80FF_1234, 0, 1, 1'b0, 1'b0, 32'h0000_0100, 4'b0100, 32'h0,         32'h0000_00FF};
        vecs[13] = '{OP_LB,  32'h0000_0102, 32'h0,         32'h80FF_1234, 0, 0, 1'b0, 1'b0, 32'h0000_0100, 4'b0100, 32'h0,         32'hFFFF_FFFF};
        vecs[14] = '{OP_SH,  32'h0000_0010, 32'hFFFF_5A3C, 32'h0,        0, 0, 1'b0, 1'b1, 32'h0000_0010, 4'b0011, 32'h5A3C_5A3C, 32'h0};

        quiet_inputs();
        #1;
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_mis", {31'b0, misaligned_o}, 32'd0);
        chk("rst_req", {31'b0, l1d_req_o}, 32'd0);
        chk("rst_we", {31'b0, l1d_we_o}, 32'd0);
        chk("rst_addr", l1d_addr_o, 32'h0);
        chk("rst_be", {28'b0, l1d_be_o}, 32'h0);
        chk("rst_wdata", l1d_wdata_o, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Load flushed in WAIT_RSP; rvalid arrives three cycles later.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = OP_LW; req_addr_i = 32'h40;
        @(negedge clk_i);
        req_valid_i = 1'b0; req_op_i = OP_NOP; l1d_gnt_i = 1'b1;
        #1 chk("fl_req", {31'b0, l1d_req_o}, 32'd1);
        @(negedge clk_i);
        l1d_gnt_i = 1'b0; flush_i = 1'b1;
        #1 chk("fl_wait_stall", {31'b0, stall_o}, 32'd1);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1 chk("fl_drain_stall0", {31'b0, stall_o}, 32'd1);
        chk("fl_drain_done0", {31'b0, done_o}, 32'd0);
        @(negedge clk_i);
        #1 chk("fl_drain_stall1", {31'b0, stall_o}, 32'd1);
        @(negedge clk_i);
        l1d_rvalid_i = 1'b1; l1d_rdata_i = 32'hCAFE_F00D;
        #1 chk("fl_drain_stall2", {31'b0, stall_o}, 32'd1);
        chk("fl_drain_done2", {31'b0, done_o}, 32'd0);
        @(negedge clk_i);
        l1d_rvalid_i = 1'b0; l1d_rdata_i = 32'hDEAD_0000;
        #1 chk("fl_idle_stall", {31'b0, stall_o}, 32'd0);
        chk("fl_idle_done", {31'b0, done_o}, 32'd0);
        chk("fl_rdata_keep", rdata_o, hold_rdata);

        // Stray rvalid while idle must not touch rdata_o.
        @(negedge clk_i);
        l1d_rvalid_i = 1'b1; l1d_rdata_i = 32'h1357_9BDF;
        @(negedge clk_i);
        l1d_rvalid_i = 1'b0; l1d_rdata_i = 32'hDEAD_0000;
        #1 chk("stray_rdata", rdata_o, hold_rdata);
        chk("stray_done", {31'b0, done_o}, 32'd0);

        // Flush in REQ without grant: abandon, no done.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = OP_SW; req_addr_i = 32'h44; req_wdata_i = 32'h1;
        @(negedge clk_i);
        req_valid_i = 1'b0; req_op_i = OP_NOP; flush_i = 1'b1;
        #1 chk("flreq_req", {31'b0, l1d_req_o}, 32'd1);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1 chk("flreq_noreq", {31'b0, l1d_req_o}, 32'd0);
        chk("flreq_nodone", {31'b0, done_o}, 32'd0);
        chk("flreq_nostall", {31'b0, stall_o}, 32'd0);

        // Flush in REQ together with grant on a store: completes silently.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = OP_SW; req_addr_i = 32'h48; req_wdata_i = 32'h2;
        @(negedge clk_i);
        req_valid_i = 1'b0; req_op_i = OP_NOP; flush_i = 1'b1; l1d_gnt_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; l1d_gnt_i = 1'b0;
        #1 chk("flst_nodone", {31'b0, done_o}, 32'd0);
        chk("flst_nostall", {31'b0, stall_o}, 32'd0);
        chk("flst_noreq", {31'b0, l1d_req_o}, 32'd0);

        // Flush has priority over a request in IDLE; non-memory ops are ignored.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = OP_SW; req_addr_i = 32'h4C; flush_i = 1'b1;
        #1 chk("flpri_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk_i);
        req_op_i = OP_ADD; req_addr_i = 32'h1; flush_i = 1'b0;
        #1 chk("flpri_noreq", {31'b0, l1d_req_o}, 32'd0);
        chk("alu_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk_i);
        req_valid_i = 1'b0; req_op_i = OP_NOP;
        #1 chk("alu_noreq", {31'b0, l1d_req_o}, 32'd0);
        chk("alu_nomis", {31'b0, misaligned_o}, 32'd0);

        // Back-to-back LW then SW with req_valid_i held through DONE.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = OP_LW; req_addr_i = 32'h10;
        @(negedge clk_i);
        req_op_i = OP_SW; req_addr_i = 32'h14; req_wdata_i = 32'h0BAD_C0DE; l1d_gnt_i = 1'b1;
        #1 chk("b2b_req1", {31'b0, l1d_req_o}, 32'd1);
        chk("b2b_addr1", l1d_addr_o, 32'h10);
        chk("b2b_stall1", {31'b0, stall_o}, 32'd1);
        @(negedge clk_i);
        l1d_gnt_i = 1'b0; l1d_rvalid_i = 1'b1; l1d_rdata_i = 32'h55AA_33CC;
        @(negedge clk_i);
        l1d_rvalid_i = 1'b0; l1d_rdata_i = 32'hDEAD_0000;
        #1 chk("b2b_done1", {31'b0, done_o}, 32'd1);
        chk("b2b_rdata1", rdata_o, 32'h55AA_33CC);
        chk("b2b_stall_acc", {31'b0, stall_o}, 32'd1);
        hold_rdata = 32'h55AA_33CC;
        @(negedge clk_i);
        req_valid_i = 1'b0; req_op_i = OP_NOP; l1d_gnt_i = 1'b1;
        #1 chk("b2b_req2", {31'b0, l1d_req_o}, 32'd1);
        chk("b2b_we2", {31'b0, l1d_we_o}, 32'd1);
        chk("b2b_addr2", l1d_addr_o, 32'h14);
        chk("b2b_wdata2", l1d_wdata_o, 32'h0BAD_C0DE);
        chk("b2b_nodone2", {31'b0, done_o}, 32'd0);
        @(negedge clk_i);
        l1d_gnt_i = 1'b0;
        #1 chk("b2b_done2", {31'b0, done_o}, 32'd1);
        chk("b2b_stall2", {31'b0, stall_o}, 32'd0);
        chk("b2b_rdata2", rdata_o, hold_rdata);
        @(negedge clk_i);
        #1 chk("b2b_idle", {31'b0, done_o}, 32'd0);

        // Reset dropped while in REQ clears everything without a clock edge.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = OP_SW; req_addr_i = 32'h80; req_wdata_i = 32'h1122_3344;
        @(negedge clk_i);
        quiet_inputs();
        #1 chk("mr_req", {31'b0, l1d_req_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1 chk("mr_req0", {31'b0, l1d_req_o}, 32'd0);
        chk("mr_we0", {31'b0, l1d_we_o}, 32'd0);
        chk("mr_addr0", l1d_addr_o, 32'h0);
        chk("mr_be0", {28'b0, l1d_be_o}, 32'h0);
        chk("mr_wdata0", l1d_wdata_o, 32'h0);
        chk("mr_stall0", {31'b0, stall_o}, 32'd0);
        chk("mr_done0", {31'b0, done_o}, 32'd0);
        chk("mr_rdata0", rdata_o, 32'h0);
        hold_rdata = 32'h0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_vec("post_rst_sb", '{OP_SB, 32'h0000_0003, 32'h0000_005A, 32'h0, 0, 0, 1'b0, 1'b1,
                                 32'h0000_0000, 4'b1000, 32'h5A5A_5A5A, 32'h0});

        repeat (2) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
